// File: rtl/rdc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rdc_ctrl_pkg
//   Shared types and constants for the RDC quota controller.
//   - rdc_state_t  : controller state, 3-bit encoding visible on state_o
//   - TRIP_CNT_MAX : saturation value of the trip counter
//   - calc_idx_w() : width of a flattened core*events+event index
// ---------------------------------------------------------------------------
package rdc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_TRIPPED = 3'd3,
        ST_CLEAR   = 3'd4
    } rdc_state_t;

    localparam int         TRIP_CNT_W   = 8;
    localparam logic [7:0] TRIP_CNT_MAX = 8'd255;

    // A single-entry map still needs a 1-bit index port.
    function automatic int calc_idx_w(input int n_cores, input int core_events);
        int n_entries;
        n_entries = n_cores * core_events;
        return (n_entries > 1) ? $clog2(n_entries) : 1;
    endfunction

endpackage

// File: rtl/rdc_first_set.sv
// ---------------------------------------------------------------------------
// rdc_first_set
//   Combinational lowest-set-bit priority encoder.
//   Ports:
//     vec_i   [N-1:0]      input vector
//     idx_o   [IDX_W-1:0]  index of the lowest set bit (0 when vec_i == 0)
//     valid_o              at least one bit of vec_i is set
// ---------------------------------------------------------------------------
module rdc_first_set #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/rdc_quota_ctrl.sv
// ---------------------------------------------------------------------------
// rdc_quota_ctrl
//   Software-facing sequencer for one Request Duration Counter (RDC).
//   Holds the per-core/per-event weights, drives the RDC enable through an
//   IDLE/ARM/RUN/TRIPPED/CLEAR state machine, records the trip timestamp,
//   the trip count and the first offending event, and raises a level
//   interrupt while tripped.
//   Ports:
//     clk_i, rstn_i               clock, asynchronous active-low reset
//     cfg_we_i/addr_i/wdata_i     weight write (flattened core*CE+event)
//     cfg_err_o                   1-cycle pulse for a rejected write
//     cmd_start_i, cmd_stop_i     software start / stop pulses
//     irq_ack_i                   interrupt acknowledge pulse
//     interruption_rdc_i          RDC combined interrupt
//     interruption_vector_rdc_i   RDC sticky per-event vector [core][event]
//     rdc_enable_o                RDC enable
//     events_weights_o            weights to the RDC [core][event]
//     irq_o                       level interrupt (TRIPPED)
//     state_o                     current state encoding
//     first_valid_o, first_idx_o  lowest offending flattened index
//     trip_time_o                 RUN cycles elapsed at the trip
//     trip_count_o                trips since the last start, saturating
// ---------------------------------------------------------------------------
module rdc_quota_ctrl
    import rdc_ctrl_pkg::*;
#(
    parameter int N_CORES       = 2,
    parameter int CORE_EVENTS   = 4,
    parameter int WEIGHTS_WIDTH = 8,
    parameter int TS_WIDTH      = 32,
    parameter int IDX_W         = calc_idx_w(N_CORES, CORE_EVENTS)
) (
    input  logic                                                clk_i,
    input  logic                                                rstn_i,
    input  logic                                                cfg_we_i,
    input  logic [IDX_W-1:0]                                    cfg_addr_i,
    input  logic [WEIGHTS_WIDTH-1:0]                            cfg_wdata_i,
    output logic                                                cfg_err_o,
    input  logic                                                cmd_start_i,
    input  logic                                                cmd_stop_i,
    input  logic                                                irq_ack_i,
    input  logic                                                interruption_rdc_i,
    input  logic [N_CORES-1:0][CORE_EVENTS-1:0]                 interruption_vector_rdc_i,
    output logic                                                rdc_enable_o,
    output logic [N_CORES-1:0][CORE_EVENTS-1:0][WEIGHTS_WIDTH-1:0] events_weights_o,
    output logic                                                irq_o,
    output logic [2:0]                                          state_o,
    output logic                                                first_valid_o,
    output logic [IDX_W-1:0]                                    first_idx_o,
    output logic [TS_WIDTH-1:0]                                 trip_time_o,
    output logic [TRIP_CNT_W-1:0]                               trip_count_o
);

    localparam int N_ENTRIES = N_CORES * CORE_EVENTS;

    rdc_state_t                                state_reg;
    rdc_state_t                                state_next;

    logic [N_ENTRIES-1:0][WEIGHTS_WIDTH-1:0]  weights_reg;
    logic [N_ENTRIES-1:0]                     wr_sel;
    logic                                     addr_in_range;
    logic                                     wr_accept;
    logic                                     cfg_err_reg;

    logic [TS_WIDTH-1:0]                      ts_reg;
    logic [TS_WIDTH-1:0]                      trip_time_reg;
    logic [TRIP_CNT_W-1:0]                    trip_count_reg;
    logic                                     first_valid_reg;
    logic [IDX_W-1:0]                         first_idx_reg;

    logic [N_ENTRIES-1:0]                     vec_flat;
    logic [IDX_W-1:0]                         lowest_idx;
    logic                                     lowest_valid;

    logic                                     start_accept;
    logic                                     trip_entry;
    logic                                     capture_first;

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stop always wins; start is only meaningful in IDLE and ack only in
    // TRIPPED, so they are simply not looked at elsewhere.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_start_i && !cmd_stop_i) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                state_next = cmd_stop_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (cmd_stop_i) begin
                    state_next = ST_IDLE;
                end else if (interruption_rdc_i) begin
                    state_next = ST_TRIPPED;
                end
            end
            ST_TRIPPED: begin
                if (cmd_stop_i) begin
                    state_next = ST_IDLE;
                end else if (irq_ack_i) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_next = cmd_stop_i ? ST_IDLE : ST_RUN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign start_accept = (state_reg == ST_IDLE) && (state_next == ST_ARM);
    assign trip_entry   = (state_reg == ST_RUN)  && (state_next == ST_TRIPPED);

    // -----------------------------------------------------------------------
    // Weight registers
    // -----------------------------------------------------------------------
    // With a power-of-two map every encodable address is a real entry.
    generate
        if (N_ENTRIES == (1 << IDX_W)) begin : g_full_range
            assign addr_in_range = 1'b1;
        end else begin : g_partial_range
            assign addr_in_range = (int'(cfg_addr_i) < N_ENTRIES);
        end
    endgenerate

    assign wr_accept = cfg_we_i && (state_reg == ST_IDLE) && addr_in_range;

    genvar gi;
    generate
        for (gi = 0; gi < N_ENTRIES; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_accept && (cfg_addr_i == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            weights_reg <= '1;
            cfg_err_reg <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (wr_sel[i]) begin
                    weights_reg[i] <= cfg_wdata_i;
                end
            end
            cfg_err_reg <= cfg_we_i && !wr_accept;
        end
    end

    // -----------------------------------------------------------------------
    // Timestamp, trip bookkeeping and first-offender capture
    // -----------------------------------------------------------------------
    // ARM and CLEAR are the one-cycle windows where the RDC is flushed, so
    // the run-time base restarts there.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ts_reg <= '0;
        end else begin
            case (state_reg)
                ST_ARM, ST_CLEAR: ts_reg <= '0;
                ST_RUN: begin
                    if (ts_reg != '1) begin
                        ts_reg <= ts_reg + TS_WIDTH'(1);
                    end
                end
                default: ts_reg <= ts_reg;
            endcase
        end
    end

    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_vec_flat
            assign vec_flat[gi*CORE_EVENTS +: CORE_EVENTS] = interruption_vector_rdc_i[gi];
        end
    endgenerate

    rdc_first_set #(
        .N     (N_ENTRIES),
        .IDX_W (IDX_W)
    ) u_first_set (
        .vec_i   (vec_flat),
        .idx_o   (lowest_idx),
        .valid_o (lowest_valid)
    );

    // The sticky vector trails the combined interrupt by one cycle, so the
    // capture is armed for the whole TRIPPED stay and fires once.
    assign capture_first = (state_reg == ST_TRIPPED) && lowest_valid && !first_valid_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            trip_time_reg   <= '0;
            trip_count_reg  <= '0;
            first_valid_reg <= 1'b0;
            first_idx_reg   <= '0;
        end else begin
            if (start_accept) begin
                trip_time_reg   <= '0;
                trip_count_reg  <= '0;
                first_valid_reg <= 1'b0;
            end else if (trip_entry) begin
                trip_time_reg   <= ts_reg;
                first_valid_reg <= 1'b0;
                if (trip_count_reg != TRIP_CNT_MAX) begin
                    trip_count_reg <= trip_count_reg + TRIP_CNT_W'(1);
                end
            end else if (capture_first) begin
                first_idx_reg   <= lowest_idx;
                first_valid_reg <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Enable stays high in TRIPPED so the RDC keeps its sticky state for
    // software to inspect.
    assign rdc_enable_o     = (state_reg == ST_RUN) || (state_reg == ST_TRIPPED);
    assign irq_o            = (state_reg == ST_TRIPPED);
    assign state_o          = state_reg;
    assign cfg_err_o        = cfg_err_reg;
    assign events_weights_o = weights_reg;
    assign first_valid_o    = first_valid_reg;
    assign first_idx_o      = first_idx_reg;
    assign trip_time_o      = trip_time_reg;
    assign trip_count_o     = trip_count_reg;

endmodule

// File: tb/tb_rdc_quota_ctrl.sv
module tb_rdc_quota_ctrl;

    localparam int SIG_STATE  = 0;
    localparam int SIG_EN     = 1;
    localparam int SIG_IRQ    = 2;
    localparam int SIG_ERR    = 3;
    localparam int SIG_FVALID = 4;
    localparam int SIG_FIDX   = 5;
    localparam int SIG_TTIME  = 6;
    localparam int SIG_TCOUNT = 7;
    localparam int SIG_WEIGHT = 8;
    localparam int SIG_ERR3   = 9;
    localparam int SIG_W3     = 10;

    typedef struct {
        string       tag;
        int          sig;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    // Main instance: default 2 cores x 4 events
    logic                 cfg_we    = 1'b0;
    logic [2:0]           cfg_addr  = '0;
    logic [7:0]           cfg_wdata = '0;
    logic                 cfg_err;
    logic                 cmd_start = 1'b0;
    logic                 cmd_stop  = 1'b0;
    logic                 irq_ack   = 1'b0;
    logic                 irq_in    = 1'b0;
    logic [1:0][3:0]      vec       = '0;
    logic                 rdc_enable;
    logic [1:0][3:0][7:0] weights;
    logic                 irq;
    logic [2:0]           state;
    logic                 first_valid;
    logic [2:0]           first_idx;
    logic [31:0]          trip_time;
    logic [7:0]           trip_count;

    // Second instance: 3 cores x 2 events, so indices 6 and 7 are encodable
    // but out of range (index 8 cannot be encoded on a 3-bit 2x4 address).
    logic                 cfg3_we    = 1'b0;
    logic [2:0]           cfg3_addr  = '0;
    logic [7:0]           cfg3_wdata = '0;
    logic                 cfg3_err;
    logic                 tie0       = 1'b0;
    logic [2:0][1:0]      vec3       = '0;
    logic                 en3, irq3, fv3;
    logic [2:0]           st3, fi3;
    logic [31:0]          tt3;
    logic [7:0]           tc3;
    logic [2:0][1:0][7:0] w3;

    always #5 clk = ~clk;

    rdc_quota_ctrl u_dut (
        .clk_i                     (clk),
        .rstn_i                    (rstn),
        .cfg_we_i                  (cfg_we),
        .cfg_addr_i                (cfg_addr),
        .cfg_wdata_i               (cfg_wdata),
        .cfg_err_o                 (cfg_err),
        .cmd_start_i               (cmd_start),
        .cmd_stop_i                (cmd_stop),
        .irq_ack_i                 (irq_ack),
        .interruption_rdc_i        (irq_in),
        .interruption_vector_rdc_i (vec),
        .rdc_enable_o              (rdc_enable),
        .events_weights_o          (weights),
        .irq_o                     (irq),
        .state_o                   (state),
        .first_valid_o             (first_valid),
        .first_idx_o               (first_idx),
        .trip_time_o               (trip_time),
        .trip_count_o              (trip_count)
    );

    rdc_quota_ctrl #(
        .N_CORES     (3),
        .CORE_EVENTS (2)
    ) u_dut3 (
        .clk_i                     (clk),
        .rstn_i                    (rstn),
        .cfg_we_i                  (cfg3_we),
        .cfg_addr_i                (cfg3_addr),
        .cfg_wdata_i               (cfg3_wdata),
        .cfg_err_o                 (cfg3_err),
        .cmd_start_i               (tie0),
        .cmd_stop_i                (tie0),
        .irq_ack_i                 (tie0),
        .interruption_rdc_i        (tie0),
        .interruption_vector_rdc_i (vec3),
        .rdc_enable_o              (en3),
        .events_weights_o          (w3),
        .irq_o                     (irq3),
        .state_o                   (st3),
        .first_valid_o             (fv3),
        .first_idx_o               (fi3),
        .trip_time_o               (tt3),
        .trip_count_o              (tc3)
    );

    function automatic logic [31:0] observe(input int sig, input int idx);
        logic [63:0] wf;
        logic [47:0] wf3;
        wf  = weights;
        wf3 = w3;
        case (sig)
            SIG_STATE:  return 32'(state);
            SIG_EN:     return 32'(rdc_enable);
            SIG_IRQ:    return 32'(irq);
            SIG_ERR:    return 32'(cfg_err);
            SIG_FVALID: return 32'(first_valid);
            SIG_FIDX:   return 32'(first_idx);
            SIG_TTIME:  return trip_time;
            SIG_TCOUNT: return 32'(trip_count);
            SIG_WEIGHT: return 32'(wf[idx*8 +: 8]);
            SIG_ERR3:   return 32'(cfg3_err);
            SIG_W3:     return 32'(wf3[idx*8 +: 8]);
            default:    return 'x;
        endcase
    endfunction

    task automatic sb_push(input string tag, input int sig, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.idx = idx;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sig, e.idx);
            vectors++;
            assert (obs === e.val) begin
                $display("[%0t] %s = 0x%0h ok", $time, e.tag, obs);
            end else begin
                miscompares++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock edge, then compare everything queued for it; pulses drop.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        irq_ack   = 1'b0;
        cfg_we    = 1'b0;
        cfg3_we   = 1'b0;
        drain();
    endtask

    initial begin
        repeat (2) @(negedge clk);

        // Reset values
        sb_push("rst_state", SIG_STATE, 0, 0);
        sb_push("rst_en", SIG_EN, 0, 0);
        sb_push("rst_irq", SIG_IRQ, 0, 0);
        sb_push("rst_err", SIG_ERR, 0, 0);
        sb_push("rst_fvalid", SIG_FVALID, 0, 0);
        sb_push("rst_fidx", SIG_FIDX, 0, 0);
        sb_push("rst_ttime", SIG_TTIME, 0, 0);
        sb_push("rst_tcount", SIG_TCOUNT, 0, 0);
        sb_push("rst_w0", SIG_WEIGHT, 0, 32'hFF);
        sb_push("rst_w5", SIG_WEIGHT, 5, 32'hFF);
        sb_push("rst_w3_0", SIG_W3, 0, 32'hFF);
        drain();
        rstn = 1'b1;

        // Weight write idx 5 = 3 in IDLE
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = 8'd3;
        sb_push("wr_w5", SIG_WEIGHT, 5, 3);
        sb_push("wr_w4", SIG_WEIGHT, 4, 32'hFF);
        sb_push("wr_err", SIG_ERR, 0, 0);
        cycle();

        // Start: IDLE -> ARM -> RUN
        cmd_start = 1'b1;
        sb_push("start_state", SIG_STATE, 0, 1);
        sb_push("arm_en", SIG_EN, 0, 0);
        cycle();
        sb_push("run_state", SIG_STATE, 0, 2);
        sb_push("run_en", SIG_EN, 0, 1);
        cycle();

        // RUN cycle 0: write is rejected
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 8'h55;
        sb_push("runwr_err", SIG_ERR, 0, 1);
        sb_push("runwr_w1", SIG_WEIGHT, 1, 32'hFF);
        sb_push("runwr_state", SIG_STATE, 0, 2);
        cycle();
        sb_push("runwr_err_end", SIG_ERR, 0, 0);
        cycle();
        for (int i = 0; i < 8; i++) cycle();

        // RUN cycle 10: trip
        irq_in = 1'b1;
        sb_push("trip_state", SIG_STATE, 0, 3);
        sb_push("trip_irq", SIG_IRQ, 0, 1);
        sb_push("trip_en", SIG_EN, 0, 1);
        sb_push("trip_ttime", SIG_TTIME, 0, 10);
        sb_push("trip_tcount", SIG_TCOUNT, 0, 1);
        sb_push("trip_fvalid", SIG_FVALID, 0, 0);
        cycle();

        // First TRIPPED cycle: vector idx 2 and 6 appear
        irq_in = 1'b0;
        vec = '0; vec[0][2] = 1'b1; vec[1][2] = 1'b1;
        sb_push("cap_state", SIG_STATE, 0, 3);
        sb_push("cap_fidx", SIG_FIDX, 0, 2);
        sb_push("cap_fvalid", SIG_FVALID, 0, 1);
        cycle();

        // Lower bit appears later: no recapture; ack -> CLEAR
        vec = '0; vec[0][0] = 1'b1;
        irq_ack = 1'b1;
        sb_push("ack_state", SIG_STATE, 0, 4);
        sb_push("clr_en", SIG_EN, 0, 0);
        sb_push("clr_irq", SIG_IRQ, 0, 0);
        sb_push("clr_fidx", SIG_FIDX, 0, 2);
        cycle();
        vec = '0;
        sb_push("clr_run_state", SIG_STATE, 0, 2);
        sb_push("clr_run_en", SIG_EN, 0, 1);
        sb_push("clr_keep_fidx", SIG_FIDX, 0, 2);
        sb_push("clr_keep_ttime", SIG_TTIME, 0, 10);
        cycle();

        // Ack outside TRIPPED ignored (RUN cycle 0 after CLEAR)
        irq_ack = 1'b1;
        sb_push("ack_run_ignored", SIG_STATE, 0, 2);
        cycle();

        // Second trip at RUN cycle 1
        irq_in = 1'b1;
        sb_push("trip2_ttime", SIG_TTIME, 0, 1);
        sb_push("trip2_tcount", SIG_TCOUNT, 0, 2);
        sb_push("trip2_fvalid", SIG_FVALID, 0, 0);
        cycle();

        // Ack in the entry cycle honoured; capture idx 5 on the same edge
        irq_in = 1'b0;
        vec = '0; vec[1][1] = 1'b1;
        irq_ack = 1'b1;
        sb_push("ack_entry_state", SIG_STATE, 0, 4);
        sb_push("cap2_fidx", SIG_FIDX, 0, 5);
        sb_push("cap2_fvalid", SIG_FVALID, 0, 1);
        cycle();

        // Stop in CLEAR
        vec = '0;
        cmd_stop = 1'b1;
        sb_push("clr_stop_state", SIG_STATE, 0, 0);
        sb_push("idle_en", SIG_EN, 0, 0);
        cycle();

        // Start+stop together stays IDLE
        cmd_start = 1'b1; cmd_stop = 1'b1;
        sb_push("startstop_state", SIG_STATE, 0, 0);
        cycle();

        // IDLE writes: in-range accepted; 3x2 build rejects idx 6
        cfg_we = 1'b1; cfg_addr = 3'd7; cfg_wdata = 8'hA5;
        cfg3_we = 1'b1; cfg3_addr = 3'd6; cfg3_wdata = 8'h77;
        sb_push("idle_w7", SIG_WEIGHT, 7, 32'hA5);
        sb_push("idle_err", SIG_ERR, 0, 0);
        sb_push("idle_w5_kept", SIG_WEIGHT, 5, 3);
        sb_push("oor_err", SIG_ERR3, 0, 1);
        cycle();
        cfg3_we = 1'b1; cfg3_addr = 3'd5; cfg3_wdata = 8'h12;
        sb_push("oor_err_end", SIG_ERR3, 0, 0);
        sb_push("w3_5", SIG_W3, 5, 32'h12);
        sb_push("w3_0_kept", SIG_W3, 0, 32'hFF);
        cycle();

        // Start clears trip info; stop in ARM returns to IDLE
        cmd_start = 1'b1;
        sb_push("restart_state", SIG_STATE, 0, 1);
        sb_push("restart_tcount", SIG_TCOUNT, 0, 0);
        sb_push("restart_fvalid", SIG_FVALID, 0, 0);
        sb_push("restart_ttime", SIG_TTIME, 0, 0);
        cycle();
        cmd_stop = 1'b1;
        sb_push("arm_stop_state", SIG_STATE, 0, 0);
        cycle();

        // Stop+ack together in TRIPPED -> IDLE
        cmd_start = 1'b1;
        cycle();
        sb_push("run3_state", SIG_STATE, 0, 2);
        cycle();
        irq_in = 1'b1;
        sb_push("trip3_tcount", SIG_TCOUNT, 0, 1);
        cycle();
        irq_in = 1'b0;
        cmd_stop = 1'b1; irq_ack = 1'b1;
        sb_push("stopack_state", SIG_STATE, 0, 0);
        sb_push("stopack_irq", SIG_IRQ, 0, 0);
        sb_push("stopack_tcount", SIG_TCOUNT, 0, 1);
        cycle();

        // 300 trip/ack rounds: count saturates at 255
        cmd_start = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 300; i++) begin
            irq_in = 1'b1;
            sb_push("sat_tcount", SIG_TCOUNT, 0, (i + 1 > 255) ? 255 : i + 1);
            cycle();
            irq_in  = 1'b0;
            irq_ack = 1'b1;
            cycle();
            cycle();
        end

        // Trip once more, then asynchronous reset mid-TRIPPED
        irq_in = 1'b1;
        sb_push("final_trip_state", SIG_STATE, 0, 3);
        sb_push("final_tcount", SIG_TCOUNT, 0, 255);
        cycle();
        irq_in = 1'b0;
        #2 rstn = 1'b0;
        #1;
        sb_push("async_state", SIG_STATE, 0, 0);
        sb_push("async_irq", SIG_IRQ, 0, 0);
        sb_push("async_en", SIG_EN, 0, 0);
        sb_push("async_w5", SIG_WEIGHT, 5, 32'hFF);
        sb_push("async_w7", SIG_WEIGHT, 7, 32'hFF);
        sb_push("async_tcount", SIG_TCOUNT, 0, 0);
        drain();
        sb_push("held_state", SIG_STATE, 0, 0);
        cycle();
        rstn = 1'b1;
        sb_push("post_rst_state", SIG_STATE, 0, 0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
